// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud arithmetic and default constants.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int CLOCK_FREQ_DEFAULT = 50_000_000;
    localparam int BAUD_RATE_DEFAULT  = 115_200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    // Clocks per bit; integer division truncates, so the real rate is slightly fast.
    function automatic int baud_ticks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO feeding the UART transmitter.
// Full/empty derive from the registered count, so a write is judged against the
// occupancy before any same-edge read.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because the count guards every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; count moves only when exactly one side acts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, fronted by a byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = CLOCK_FREQ_DEFAULT,
    parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_wr,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          BAUD_TICKS = baud_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam logic [15:0] RELOAD     = 16'(BAUD_TICKS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_wr),
        .wr_data (data_in),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign ready = !fifo_full;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE) || (fifo_count != '0);

    // State, bit timer, bit index, held byte and line level all register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic: each bit holds for BAUD_TICKS clocks, frames chain without gaps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        fifo_rd = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    shift_d = fifo_rd_data;
                    tx_d    = 1'b0;
                    cnt_d   = RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    cnt_d   = RELOAD;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = RELOAD;
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shift_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    tx_d    = 1'b1;
                    cnt_d   = RELOAD;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        fifo_rd = 1'b1;
                        shift_d = fifo_rd_data;
                        tx_d    = 1'b0;
                        cnt_d   = RELOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule
